// File: rtl/weather_sensor_sequencer.sv
// weather_sensor_sequencer
//
// Polls the four weather sensors over one shared request/acknowledge bus.
// It assembles a coherent snapshot of wind, visibility, temperature and
// thunderstorm, and presents that snapshot to the ECSU severity FSM as
// registered outputs. Snapshot outputs change only when a full round has
// completed, so the ECSU never sees values taken from different rounds.
//
// Optional feature: define WSS_TIMEOUT_EN to add a per-transaction timeout.
// With it, a sensor that stays silent for TIMEOUT request cycles is reported
// through sensor_fault/fault_id, and the round is abandoned (no publish).
// Without it, a request waits indefinitely and sensor_fault/fault_id are 0.
//
// Parameters:
//   PERIOD   cycles spent in WAIT between rounds (>= 1)
//   TIMEOUT  request cycles without ack before a fault (>= 1, WSS_TIMEOUT_EN only)
//
// Ports:
//   CLK, RST        clock, asynchronous active-high reset
//   enable          start/continue periodic polling (sampled in IDLE and last WAIT cycle)
//   sens_req        bus request, held until ack (or timeout)
//   sens_sel        sensor select: 0 wind, 1 visibility, 2 temperature, 3 thunderstorm
//   sens_ack        sensor drives valid sens_data this cycle (honoured only in REQ)
//   sens_data       raw sensor value
//   thunderstorm, wind, visibility, temperature   snapshot to ECSU
//   snapshot_valid  one-cycle pulse on the edge the snapshot outputs update
//   sensor_fault    a sensor timed out; sticky until the next successful publish
//   fault_id        sens_sel of the most recent timed-out sensor
//   seq_state       FSM state: IDLE 0, REQ 1, GAP 2, PUBLISH 3, WAIT 4
//
// Bus handshake: sens_req rises on the edge that enters REQ and stays high,
// with sens_sel stable, until the edge on which sens_ack=1 is sampled (or the
// timeout fires). The sensor may hold off sens_ack for any number of cycles.
// Each sens_ack sampled during REQ transfers exactly one sens_data byte.
module weather_sensor_sequencer #(
    parameter int PERIOD  = 1000,
    parameter int TIMEOUT = 15
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              enable,
    output logic              sens_req,
    output logic [1:0]        sens_sel,
    input  logic              sens_ack,
    input  logic [7:0]        sens_data,
    output logic              thunderstorm,
    output logic [5:0]        wind,
    output logic [1:0]        visibility,
    output logic signed [7:0] temperature,
    output logic              snapshot_valid,
    output logic              sensor_fault,
    output logic [1:0]        fault_id,
    output logic [2:0]        seq_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_GAP     = 3'd2,
        S_PUBLISH = 3'd3,
        S_WAIT    = 3'd4
    } state_t;

    localparam logic [15:0] WAIT_LOAD = 16'(PERIOD - 1);

    state_t            state;
    logic [1:0]        idx;
    logic [15:0]       wait_cnt;

    // Shadow registers hold the converted values of the round in progress.
    logic              sh_thunder;
    logic [5:0]        sh_wind;
    logic [1:0]        sh_vis;
    logic signed [7:0] sh_temp;

`ifdef WSS_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
    logic [15:0] req_cnt;
`endif

    assign seq_state = state;
    // idx only changes outside REQ, so it can drive the select directly.
    assign sens_sel  = idx;

`ifndef WSS_TIMEOUT_EN
    assign sensor_fault = 1'b0;
    assign fault_id     = 2'd0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state          <= S_IDLE;
            idx            <= 2'd0;
            wait_cnt       <= 16'd0;
            sens_req       <= 1'b0;
            sh_thunder     <= 1'b0;
            sh_wind        <= 6'd0;
            sh_vis         <= 2'd0;
            sh_temp        <= 8'sd0;
            thunderstorm   <= 1'b0;
            wind           <= 6'd0;
            visibility     <= 2'd0;
            temperature    <= 8'sd0;
            snapshot_valid <= 1'b0;
`ifdef WSS_TIMEOUT_EN
            req_cnt        <= 16'd0;
            sensor_fault   <= 1'b0;
            fault_id       <= 2'd0;
`endif
        end else begin
            snapshot_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    sens_req <= 1'b0;
                    if (enable) begin
                        state    <= S_REQ;
                        idx      <= 2'd0;
                        sens_req <= 1'b1;
`ifdef WSS_TIMEOUT_EN
                        req_cnt  <= 16'd0;
`endif
                    end
                end

                S_REQ: begin
                    if (sens_ack) begin
                        case (idx)
                            2'd0:    sh_wind    <= (sens_data[7:6] != 2'b00) ? 6'd63 : sens_data[5:0];
                            2'd1:    sh_vis     <= sens_data[1:0];
                            2'd2:    sh_temp    <= $signed(sens_data);
                            default: sh_thunder <= sens_data[0];
                        endcase
                        sens_req <= 1'b0;
                        state    <= (idx == 2'd3) ? S_PUBLISH : S_GAP;
                    end
`ifdef WSS_TIMEOUT_EN
                    else if (req_cnt == TO_LAST) begin
                        // Abandon the round; the snapshot keeps last round's values.
                        sens_req     <= 1'b0;
                        sensor_fault <= 1'b1;
                        fault_id     <= idx;
                        idx          <= 2'd0;
                        wait_cnt     <= WAIT_LOAD;
                        state        <= S_WAIT;
                    end else begin
                        req_cnt <= req_cnt + 16'd1;
                    end
`endif
                end

                S_GAP: begin
                    idx      <= idx + 2'd1;
                    sens_req <= 1'b1;
                    state    <= S_REQ;
`ifdef WSS_TIMEOUT_EN
                    req_cnt  <= 16'd0;
`endif
                end

                S_PUBLISH: begin
                    thunderstorm   <= sh_thunder;
                    wind           <= sh_wind;
                    visibility     <= sh_vis;
                    temperature    <= sh_temp;
                    snapshot_valid <= 1'b1;
`ifdef WSS_TIMEOUT_EN
                    sensor_fault   <= 1'b0;
`endif
                    idx            <= 2'd0;
                    wait_cnt       <= WAIT_LOAD;
                    state          <= S_WAIT;
                end

                S_WAIT: begin
                    if (wait_cnt == 16'd0) begin
                        idx <= 2'd0;
                        if (enable) begin
                            state    <= S_REQ;
                            sens_req <= 1'b1;
`ifdef WSS_TIMEOUT_EN
                            req_cnt  <= 16'd0;
`endif
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 16'd1;
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    sens_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_weather_sensor_sequencer.sv
module tb_weather_sensor_sequencer;

    localparam int PERIOD  = 4;
    localparam int TIMEOUT = 3;

    logic              CLK;
    logic              RST;
    logic              enable;
    logic              sens_req;
    logic [1:0]        sens_sel;
    logic              sens_ack;
    logic [7:0]        sens_data;
    logic              thunderstorm;
    logic [5:0]        wind;
    logic [1:0]        visibility;
    logic signed [7:0] temperature;
    logic              snapshot_valid;
    logic              sensor_fault;
    logic [1:0]        fault_id;
    logic [2:0]        seq_state;

    weather_sensor_sequencer #(.PERIOD(PERIOD), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RST(RST), .enable(enable),
        .sens_req(sens_req), .sens_sel(sens_sel), .sens_ack(sens_ack), .sens_data(sens_data),
        .thunderstorm(thunderstorm), .wind(wind), .visibility(visibility), .temperature(temperature),
        .snapshot_valid(snapshot_valid), .sensor_fault(sensor_fault), .fault_id(fault_id),
        .seq_state(seq_state)
    );

    // ---------------- clock ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- counters / scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [16:0] exp_q[$];
    logic [16:0] last_snap = 17'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [16:0] pack(input logic th, input logic [5:0] w, input logic [1:0] v, input logic [7:0] t);
        return {th, w, v, t};
    endfunction

    function automatic logic [16:0] snap_now();
        return {thunderstorm, wind, visibility, temperature};
    endfunction

    // Every publish must match the oldest expected snapshot; an empty queue means an unexpected publish.
    always @(negedge CLK) begin
        if (RST === 1'b0 && snapshot_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_publish: got snapshot 0x%0h expected no publish", snap_now());
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                if (snap_now() !== e) begin
                    failures++;
                    $display("FAIL snapshot: got 0x%0h expected 0x%0h", snap_now(), e);
                end
            end
        end
    end

    // ---------------- sensor responder ----------------
    logic [7:0] resp_data[4];
    int         resp_delay = 0;
    logic [3:0] mute       = 4'b0000;
    logic       spur       = 1'b0;
    int         rcnt       = 0;

    always @(negedge CLK) begin
        sens_ack  = 1'b0;
        sens_data = 8'h00;
        if (sens_req === 1'b1) begin
            if (!mute[sens_sel]) begin
                if (rcnt == resp_delay) begin
                    sens_ack  = 1'b1;
                    sens_data = resp_data[sens_sel];
                    rcnt      = 0;
                end else begin
                    rcnt++;
                end
            end
        end else begin
            rcnt = 0;
            if (spur) begin
                sens_ack  = 1'b1;
                sens_data = 8'hFF;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_resp(input logic [7:0] dw, input logic [7:0] dv, input logic [7:0] dt, input logic [7:0] dth);
        resp_data[0] = dw;
        resp_data[1] = dv;
        resp_data[2] = dt;
        resp_data[3] = dth;
    endtask

    // One round from IDLE with enable pulsed; enable is dropped mid-round so the block returns to IDLE.
    task automatic run_round(input string tag, input int delay, input logic [16:0] exp_snap);
        int k;
        int w;
        bit got;
        resp_delay = delay;
        exp_q.push_back(exp_snap);
        last_snap = exp_snap;
        @(negedge CLK);
        enable = 1'b1;
        k = 0;
        got = 0;
        while (k < 200 && !got) begin
            @(negedge CLK);
            k++;
            if (k == 1) enable = 1'b0;
            if (snapshot_valid === 1'b1) got = 1;
        end
        check({tag, "_latency"}, k - 1, 8 + 4 * delay);
        check({tag, "_state_wait"}, {29'd0, seq_state}, 32'd4);
        check({tag, "_fault_clear"}, {31'd0, sensor_fault}, 32'd0);
        w = 0;
        while (seq_state === 3'd4 && w < 100) begin
            @(negedge CLK);
            w++;
            if (w == 1) check({tag, "_valid_pulse"}, {31'd0, snapshot_valid}, 32'd0);
        end
        check({tag, "_wait_cycles"}, w, PERIOD);
        check({tag, "_idle"}, {29'd0, seq_state}, 32'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string      name;
        logic [7:0] d_wind, d_vis, d_temp, d_th;
        int         delay;
        logic       e_th;
        logic [5:0] e_wind;
        logic [1:0] e_vis;
        logic [7:0] e_temp;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int k;
        int n;
        int reqs;
        vecs[0] = '{"basic",     8'h0C, 8'h01, 8'hE0, 8'h00, 0, 1'b0, 6'd12, 2'd1, 8'hE0};
        vecs[1] = '{"sat_hot",   8'h50, 8'h06, 8'h29, 8'h03, 1, 1'b1, 6'd63, 2'd2, 8'h29};
        vecs[2] = '{"max_vals",  8'h2A, 8'h03, 8'h7F, 8'hFF, 2, 1'b1, 6'd42, 2'd3, 8'h7F};
        vecs[3] = '{"sat_cold",  8'hC1, 8'h00, 8'h80, 8'h02, 0, 1'b0, 6'd63, 2'd0, 8'h80};

        // reset
        RST    = 1'b1;
        enable = 1'b0;
        set_resp(8'h00, 8'h00, 8'h00, 8'h00);
        repeat (3) @(negedge CLK);
        check("rst_req",   {31'd0, sens_req}, 32'd0);
        check("rst_state", {29'd0, seq_state}, 32'd0);
        check("rst_sel",   {30'd0, sens_sel}, 32'd0);
        check("rst_snap",  {15'd0, snap_now()}, 32'd0);
        check("rst_valid", {31'd0, snapshot_valid}, 32'd0);
        check("rst_fault", {29'd0, sensor_fault, fault_id}, 32'd0);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        check("idle_hold", {29'd0, seq_state}, 32'd0);

        // table-driven rounds
        for (int i = 0; i < 4; i++) begin
            set_resp(vecs[i].d_wind, vecs[i].d_vis, vecs[i].d_temp, vecs[i].d_th);
            run_round(vecs[i].name, vecs[i].delay,
                      pack(vecs[i].e_th, vecs[i].e_wind, vecs[i].e_vis, vecs[i].e_temp));
            check({vecs[i].name, "_held"}, {15'd0, snap_now()}, {15'd0, last_snap});
        end

        // periodic polling with enable held
        set_resp(8'h0C, 8'h01, 8'hE0, 8'h00);
        resp_delay = 0;
        exp_q.push_back(pack(1'b0, 6'd12, 2'd1, 8'hE0));
        @(negedge CLK);
        enable = 1'b1;
        k = 0;
        while (k < 100 && snapshot_valid !== 1'b1) begin
            @(negedge CLK);
            k++;
        end
        check("per_first_latency", k - 1, 8);
        set_resp(8'h50, 8'h06, 8'h29, 8'h03);
        exp_q.push_back(pack(1'b1, 6'd63, 2'd2, 8'h29));
        n = 0;
        do begin
            @(negedge CLK);
            n++;
            if (n == 7) check("per_coherent_hold", {15'd0, snap_now()}, {15'd0, pack(1'b0, 6'd12, 2'd1, 8'hE0)});
        end while (n < 100 && snapshot_valid !== 1'b1);
        check("per_interval", n, PERIOD + 8);
        enable = 1'b0;
        n = 0;
        while (seq_state === 3'd4 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        check("per_wait_then_idle", n, PERIOD);
        check("per_idle", {29'd0, seq_state}, 32'd0);
        last_snap = pack(1'b1, 6'd63, 2'd2, 8'h29);

`ifdef WSS_TIMEOUT_EN
        // silent temperature sensor
        set_resp(8'h01, 8'h02, 8'h03, 8'h01);
        mute = 4'b0100;
        @(negedge CLK);
        enable = 1'b1;
        k = 0;
        reqs = 0;
        while (k < 100 && seq_state !== 3'd4) begin
            @(negedge CLK);
            k++;
            if (k == 1) enable = 1'b0;
            if (sens_req === 1'b1 && sens_sel === 2'd2) reqs++;
        end
        check("to_req_cycles", reqs, TIMEOUT);
        check("to_req_dropped", {31'd0, sens_req}, 32'd0);
        check("to_fault", {31'd0, sensor_fault}, 32'd1);
        check("to_fault_id", {30'd0, fault_id}, 32'd2);
        check("to_snap_held", {15'd0, snap_now()}, {15'd0, last_snap});
        n = 0;
        while (seq_state === 3'd4 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        check("to_wait_cycles", n, PERIOD);
        check("to_fault_sticky", {31'd0, sensor_fault}, 32'd1);
        mute = 4'b0000;
        set_resp(8'h0C, 8'h01, 8'hE0, 8'h00);
        run_round("to_recover", 0, pack(1'b0, 6'd12, 2'd1, 8'hE0));
        check("to_recover_fault", {31'd0, sensor_fault}, 32'd0);
`else
        // silent sensor simply stalls; fault outputs stay 0
        set_resp(8'h01, 8'h02, 8'h03, 8'h01);
        mute = 4'b0100;
        @(negedge CLK);
        enable = 1'b1;
        @(negedge CLK);
        enable = 1'b0;
        repeat (30) @(negedge CLK);
        check("stall_state", {29'd0, seq_state}, 32'd1);
        check("stall_req", {31'd0, sens_req}, 32'd1);
        check("stall_sel", {30'd0, sens_sel}, 32'd2);
        check("stall_no_fault", {29'd0, sensor_fault, fault_id}, 32'd0);
        check("stall_snap_held", {15'd0, snap_now()}, {15'd0, last_snap});
        mute = 4'b0000;
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        last_snap = 17'd0;
`endif

        // reset in REQ for sensor 1
        set_resp(8'h2A, 8'h03, 8'h7F, 8'hFF);
        resp_delay = 3;
        @(negedge CLK);
        enable = 1'b1;
        k = 0;
        while (k < 100 && !(sens_req === 1'b1 && sens_sel === 2'd1)) begin
            @(negedge CLK);
            k++;
        end
        check("mid_reached_req1", {31'd0, sens_req}, 32'd1);
        RST = 1'b1;
        #1;
        check("mid_rst_req", {31'd0, sens_req}, 32'd0);
        check("mid_rst_state", {29'd0, seq_state}, 32'd0);
        check("mid_rst_snap", {15'd0, snap_now()}, 32'd0);
        enable = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        // spurious acks outside REQ must be ignored
        spur = 1'b1;
        set_resp(8'h0C, 8'h01, 8'hE0, 8'h00);
        repeat (3) @(negedge CLK);
        check("spur_idle", {29'd0, seq_state}, 32'd0);
        run_round("spur", 0, pack(1'b0, 6'd12, 2'd1, 8'hE0));
        spur = 1'b0;

        repeat (3) @(negedge CLK);
        check("exp_q_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
